hilo_ctrl: RTL and testbench
============================

# hilo_ctrl

Issue/writeback controller on the initiating side of the multiply/divide unit in the soc_sram_func CPU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the EX stage and drives operands and a start pulse to the multiply/divide unit. It counts the fixed result latency, captures the unit's hi/lo outputs into the architectural HI/LO registers, and stalls the pipeline on any HI/LO access while an operation is in flight.

## Interface
- WIDTH, 32, data width
- MUL_LAT, 5, cycles from dmu_start to valid dmu_hi/dmu_lo for multiplies (≥2)
- DIV_LAT, 32, same for divides (≥2, ≤63)

- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset; asynchronous and active-low
- op_valid  in  1  EX-stage request present
- op_code  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
- src_a, src_b  in  WIDTH  rs/rt operands; MTHI/MTLO use src_a
- flush  in  1  exception/eret cancel of the in-flight operation and of this cycle's request
- stall  out  1  combinational; request not accepted this cycle
- dmu_a, dmu_b  out  WIDTH  operands held stable for the whole operation
- dmu_op  out  2  0 MULT, 1 MULTU, 2 DIV, 3 DIVU; held for the whole operation
- dmu_start  out  1  one-cycle launch pulse
- dmu_hi, dmu_lo  in  WIDTH  unit results in architectural order (LO = product low / quotient, HI = product high / remainder)
- hi, lo  out  WIDTH  architectural HI/LO registers
- rdata  out  WIDTH  MFHI/MFLO result
- rdata_valid  out  1  one-cycle pulse qualifying rdata
- busy  out  1  high in BUSY state

## Operation
- Acceptance: a request is accepted at an edge where op_valid=1, stall=0 and flush=0.
- stall = op_valid & busy & ~flush. Every op_code stalls while busy; no forwarding from the unit.
- FSM states:
  - IDLE: on an accepted op_code 0–3, register dmu_a/dmu_b/dmu_op from src_a/src_b/op_code. Set dmu_start=1 for the next cycle. Load cnt with (MUL_LAT or DIV_LAT)−1. Go to BUSY.
  - BUSY: dmu_start=0; cnt decrements each edge. At the edge where cnt==0, hi←dmu_hi and lo←dmu_lo, then go to IDLE.
- MTHI/MTLO (IDLE only): hi/lo←src_a at the acceptance edge; no state change.
- MFHI/MFLO (IDLE only): at the acceptance edge, rdata←hi/lo and rdata_valid=1 for one cycle.
- flush in BUSY: go to IDLE at that edge, clear cnt, force dmu_start=0. hi/lo keep their pre-operation values; no capture occurs even if cnt==0 at the same edge.
- flush in IDLE: the concurrent request is dropped; no register changes.
- Division by zero is not detected. hi/lo take whatever the unit returns.
- Signed/unsigned interpretation belongs to the unit; this block only passes dmu_op.

## Timing
- Reset (resetn low, asynchronous):
  - state=IDLE, cnt=0.
  - hi, lo, rdata, dmu_a, dmu_b = 0; dmu_op=0.
  - dmu_start, rdata_valid, busy = 0.
  - Applies mid-operation: the in-flight result is discarded.
- Multiply accepted at edge E0: dmu_start high in cycle E0→E1; busy high from E0.
- Multiply capture edge is E0+MUL_LAT; busy falls at that edge. Divide is the same with DIV_LAT.
- A request held during BUSY is accepted at the capture edge + 1, i.e. the first edge with busy=0.
- A held MFLO after a multiply therefore returns the new LO with rdata_valid one cycle after acceptance.
- Back-to-back: a second MULT held during BUSY launches at capture edge + 1. Its dmu_start follows that edge; no bubble is inserted beyond the stall.
- MTHI/MTLO: hi/lo are visible at the acceptance edge. An MFHI on the following cycle reads the new value.
- dmu_a/dmu_b/dmu_op change only at acceptance of op_code 0–3.

## Test plan
Bench drives a behavioural unit model that presents the correct dmu_hi/dmu_lo exactly MUL_LAT/DIV_LAT cycles after dmu_start and X before that.
- Reset: release resetn, then issue MFHI and MFLO → rdata=0 both times; busy=0; dmu_start=0.
- MULT src_a=3, src_b=0xFFFFFFFE:
  - stall=1 on a held MFLO for the MUL_LAT cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA; rdata=0xFFFFFFFA.
- DIVU 7/2:
  - busy for exactly DIV_LAT cycles; single dmu_start pulse.
  - Then lo=3, hi=1.
- MTHI 0x12345678, MTLO 0x9ABCDEF0 on consecutive cycles, then MFHI, MFLO → rdata 0x12345678 then 0x9ABCDEF0; no stall.
- Prior hi=lo=0x55; DIV 100/7 with flush at cycle 10 → idle next edge; hi/lo stay 0x55; a new MULTU 2*3 then gives lo=6, hi=0.
- resetn asserted mid-DIV → hi=lo=0 immediately; busy=0; no capture at the old completion edge.

Source files
------------

// File: rtl/hilo_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_pkg / hilo_ctrl
//
// Issue/writeback controller between the EX stage and the multiply/divide unit.
// It launches MULT/MULTU/DIV/DIVU on the unit, counts the unit's fixed result
// latency, and captures the unit's hi/lo outputs into the architectural HI/LO
// registers. It also executes MTHI/MTLO/MFHI/MFLO directly against HI/LO. Any
// HI/LO request that arrives while an operation is in flight is stalled.
//
// Parameters
//   WIDTH    data width
//   MUL_LAT  cycles from dmu_start to the capture of a multiply result (>=2)
//   DIV_LAT  same for divides (>=2, <=63)
//
// Ports
//   clk, resetn        clock; asynchronous active-low reset
//   op_valid/op_code   EX-stage request and its opcode (see hilo_op_e)
//   src_a, src_b       rs/rt operands; MTHI/MTLO take their data from src_a
//   flush              cancels the in-flight operation and this cycle's request
//   stall              combinational: the request is not accepted this cycle
//   dmu_a/dmu_b/dmu_op operands and opcode for the unit, held for the whole op
//   dmu_start          one-cycle launch pulse to the unit
//   dmu_hi/dmu_lo      unit results (HI = product high / remainder,
//                      LO = product low / quotient)
//   hi, lo             architectural HI/LO registers
//   rdata/rdata_valid  MFHI/MFLO result and its one-cycle qualifier
//   busy               an operation is in flight
// -----------------------------------------------------------------------------

package hilo_pkg;

  // Opcode encoding shared with the EX stage. The low two bits of the
  // arithmetic opcodes double as the unit's dmu_op encoding.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } hilo_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } hilo_state_e;

endpackage : hilo_pkg

module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 32
) (
  input  logic             clk,
  input  logic             resetn,

  // EX-stage request
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,

  // Multiply/divide unit
  output logic [WIDTH-1:0] dmu_a,
  output logic [WIDTH-1:0] dmu_b,
  output logic [1:0]       dmu_op,
  output logic             dmu_start,
  input  logic [WIDTH-1:0] dmu_hi,
  input  logic [WIDTH-1:0] dmu_lo,

  // Architectural state and move-from results
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_valid,
  output logic             busy
);

  // The counter is loaded with LAT-1, so it only has to hold values below
  // the larger of the two latencies.
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  hilo_state_e      state_q,       state_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic [WIDTH-1:0] hi_q,          hi_d;
  logic [WIDTH-1:0] lo_q,          lo_d;
  logic [WIDTH-1:0] rdata_q,       rdata_d;
  logic             rdata_valid_q, rdata_valid_d;
  logic [WIDTH-1:0] dmu_a_q,       dmu_a_d;
  logic [WIDTH-1:0] dmu_b_q,       dmu_b_d;
  logic [1:0]       dmu_op_q,      dmu_op_d;
  logic             dmu_start_q,   dmu_start_d;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  hilo_op_e op;
  logic     busy_w;
  logic     accept;

  assign op     = hilo_op_e'(op_code);
  assign busy_w = (state_q == ST_BUSY);

  // Every opcode waits while an operation is in flight: there is no forwarding
  // from the unit, so even MTHI/MTLO must not race the pending capture.
  // A flush cancels the request outright, so it is reported as not stalled.
  assign stall  = op_valid & busy_w & ~flush;
  assign accept = op_valid & ~stall & ~flush;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    dmu_a_d       = dmu_a_q;
    dmu_b_d       = dmu_b_q;
    dmu_op_d      = dmu_op_q;
    dmu_start_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              // Operands are latched once here and held until the next
              // arithmetic acceptance, so the unit sees them stable.
              dmu_a_d     = src_a;
              dmu_b_d     = src_b;
              dmu_op_d    = op_code[1:0];
              dmu_start_d = 1'b1;
              // op_code[1] separates divides from multiplies.
              cnt_d       = op_code[1] ? DIV_CNT : MUL_CNT;
              state_d     = ST_BUSY;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            OP_MFHI: begin
              rdata_d       = hi_q;
              rdata_valid_d = 1'b1;
            end
            OP_MFLO: begin
              rdata_d       = lo_q;
              rdata_valid_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_BUSY: begin
        if (flush) begin
          // Abandon the operation: HI/LO keep their pre-operation values even
          // when this is also the capture edge.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          hi_d    = dmu_hi;
          lo_d    = dmu_lo;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers are reset along with the control state, since
  // HI/LO, rdata and the unit operands all have defined values out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state is written with non-blocking assignments so all
      // flops update together from values sampled before the edge.
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      dmu_a_q       <= '0;
      dmu_b_q       <= '0;
      dmu_op_q      <= 2'd0;
      dmu_start_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      dmu_a_q       <= dmu_a_d;
      dmu_b_q       <= dmu_b_d;
      dmu_op_q      <= dmu_op_d;
      dmu_start_q   <= dmu_start_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dmu_a       = dmu_a_q;
  assign dmu_b       = dmu_b_q;
  assign dmu_op      = dmu_op_q;
  assign dmu_start   = dmu_start_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign busy        = busy_w;

endmodule : hilo_ctrl

// File: tb/tb_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_ctrl
//
// Directed bench for hilo_ctrl. A behavioural multiply/divide unit drives
// dmu_hi/dmu_lo with the correct result only once the configured latency has
// elapsed after dmu_start, and X before that. Expected values are written out
// by hand at each step.
// -----------------------------------------------------------------------------

module tb_hilo_ctrl;
  import hilo_pkg::*;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 32;

  logic             clk;
  logic             resetn;
  logic             op_valid;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             stall;
  logic [WIDTH-1:0] dmu_a;
  logic [WIDTH-1:0] dmu_b;
  logic [1:0]       dmu_op;
  logic             dmu_start;
  logic [WIDTH-1:0] dmu_hi;
  logic [WIDTH-1:0] dmu_lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rdata;
  logic             rdata_valid;
  logic             busy;

  int n_checks;
  int n_errors;

  hilo_ctrl #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .stall       (stall),
    .dmu_a       (dmu_a),
    .dmu_b       (dmu_b),
    .dmu_op      (dmu_op),
    .dmu_start   (dmu_start),
    .dmu_hi      (dmu_hi),
    .dmu_lo      (dmu_lo),
    .hi          (hi),
    .lo          (lo),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural multiply/divide unit. m_cnt counts edges since the edge that
  // sampled dmu_start; results are presented for the cycle ending at the
  // LAT-th edge after launch and are X before that.
  // ---------------------------------------------------------------------------
  int               m_cnt;
  int               m_lat;
  logic [WIDTH-1:0] m_hi;
  logic [WIDTH-1:0] m_lo;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_cnt <= 0;
      m_lat <= MUL_LAT;
      m_hi  <= '0;
      m_lo  <= '0;
    end else if (dmu_start) begin
      logic signed [2*WIDTH-1:0] sprod;
      logic        [2*WIDTH-1:0] uprod;
      sprod = $signed({{WIDTH{dmu_a[WIDTH-1]}}, dmu_a}) *
              $signed({{WIDTH{dmu_b[WIDTH-1]}}, dmu_b});
      uprod = {{WIDTH{1'b0}}, dmu_a} * {{WIDTH{1'b0}}, dmu_b};
      m_cnt <= 1;
      m_lat <= dmu_op[1] ? DIV_LAT : MUL_LAT;
      unique case (dmu_op)
        2'd0: begin m_hi <= sprod[2*WIDTH-1:WIDTH]; m_lo <= sprod[WIDTH-1:0]; end
        2'd1: begin m_hi <= uprod[2*WIDTH-1:WIDTH]; m_lo <= uprod[WIDTH-1:0]; end
        2'd2: begin
          m_hi <= $signed(dmu_a) % $signed(dmu_b);
          m_lo <= $signed(dmu_a) / $signed(dmu_b);
        end
        default: begin
          m_hi <= dmu_a % dmu_b;
          m_lo <= dmu_a / dmu_b;
        end
      endcase
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt + 1;
    end
  end

  assign dmu_hi = (m_cnt != 0 && m_cnt >= m_lat - 1) ? m_hi : 'x;
  assign dmu_lo = (m_cnt != 0 && m_cnt >= m_lat - 1) ? m_lo : 'x;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Advance one edge and settle just after it, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic [2:0] code, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    op_valid = 1'b1;
    op_code  = code;
    src_a    = a;
    src_b    = b;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int stall_cycles;
    int busy_cycles;
    int starts;

    n_checks = 0;
    n_errors = 0;
    resetn   = 1'b0;
    op_valid = 1'b0;
    op_code  = 3'd0;
    src_a    = '0;
    src_b    = '0;
    flush    = 1'b0;

    repeat (2) tick();
    check("reset_busy", busy, 0);
    check("reset_start", dmu_start, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_rvalid", rdata_valid, 0);
    resetn = 1'b1;
    tick();

    // --- MFHI / MFLO straight out of reset -----------------------------------
    drive(OP_MFHI, '0, '0);
    check("mfhi0_stall", stall, 0);
    tick();
    check("mfhi0_rdata", rdata, 0);
    check("mfhi0_valid", rdata_valid, 1);
    drive(OP_MFLO, '0, '0);
    tick();
    check("mflo0_rdata", rdata, 0);
    check("mflo0_valid", rdata_valid, 1);
    op_valid = 1'b0;
    tick();
    check("rvalid_pulse", rdata_valid, 0);

    // --- MULT 3 * -2, with MFLO held behind it -------------------------------
    drive(OP_MULT, 32'd3, 32'hFFFF_FFFE);
    tick();
    check("mult_busy", busy, 1);
    check("mult_dmu_a", dmu_a, 32'd3);
    check("mult_dmu_b", dmu_b, 32'hFFFF_FFFE);
    check("mult_dmu_op", dmu_op, 0);
    drive(OP_MFLO, '0, '0);
    stall_cycles = 0;
    starts       = 0;
    while (stall && stall_cycles < 200) begin
      stall_cycles++;
      if (dmu_start) starts++;
      tick();
    end
    check("mult_stall_cycles", stall_cycles, MUL_LAT);
    check("mult_start_pulses", starts, 1);
    check("mult_busy_done", busy, 0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    tick();
    op_valid = 1'b0;
    check("mult_mflo_rdata", rdata, 32'hFFFF_FFFA);
    check("mult_mflo_valid", rdata_valid, 1);

    // --- DIVU 7 / 2 ------------------------------------------------------------
    drive(OP_DIVU, 32'd7, 32'd2);
    tick();
    op_valid    = 1'b0;
    busy_cycles = 0;
    starts      = 0;
    while (busy && busy_cycles < 200) begin
      busy_cycles++;
      if (dmu_start) starts++;
      tick();
    end
    check("divu_busy_cycles", busy_cycles, DIV_LAT);
    check("divu_start_pulses", starts, 1);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    // --- MTHI / MTLO back to back, then MFHI / MFLO ---------------------------
    drive(OP_MTHI, 32'h1234_5678, '0);
    check("mthi_stall", stall, 0);
    tick();
    check("mthi_hi", hi, 32'h1234_5678);
    drive(OP_MTLO, 32'h9ABC_DEF0, '0);
    check("mtlo_stall", stall, 0);
    tick();
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_hi_kept", hi, 32'h1234_5678);
    check("mtx_dmu_a_kept", dmu_a, 32'd7);
    check("mtx_dmu_op_kept", dmu_op, 3);
    drive(OP_MFHI, '0, '0);
    check("mfhi_stall", stall, 0);
    tick();
    check("mfhi_rdata", rdata, 32'h1234_5678);
    drive(OP_MFLO, '0, '0);
    check("mflo_stall", stall, 0);
    tick();
    check("mflo_rdata", rdata, 32'h9ABC_DEF0);
    check("mflo_valid", rdata_valid, 1);

    // --- DIV 100 / 7 flushed at cycle 10 --------------------------------------
    drive(OP_MTHI, 32'h55, '0);
    tick();
    drive(OP_MTLO, 32'h55, '0);
    tick();
    drive(OP_DIV, 32'd100, 32'd7);
    tick();
    op_valid = 1'b0;
    check("div_busy", busy, 1);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", busy, 0);
    check("flush_hi", hi, 32'h55);
    check("flush_lo", lo, 32'h55);
    repeat (DIV_LAT) tick();
    check("flush_nocap_hi", hi, 32'h55);
    check("flush_nocap_lo", lo, 32'h55);

    // A request under flush in IDLE is dropped.
    drive(OP_MTHI, 32'hDEAD_BEEF, '0);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    op_valid = 1'b0;
    check("idle_flush_hi", hi, 32'h55);
    check("idle_flush_busy", busy, 0);

    // MULTU 2 * 3 after the flush.
    drive(OP_MULTU, 32'd2, 32'd3);
    tick();
    op_valid = 1'b0;
    check("multu_dmu_op", dmu_op, 1);
    check("multu_dmu_a", dmu_a, 32'd2);
    check("multu_dmu_b", dmu_b, 32'd3);
    repeat (MUL_LAT - 1) tick();
    check("multu_busy_last", busy, 1);
    tick();
    check("multu_busy_done", busy, 0);
    check("multu_lo", lo, 32'd6);
    check("multu_hi", hi, 32'd0);

    // --- Reset in the middle of a DIV ------------------------------------------
    drive(OP_DIV, 32'd100, 32'd7);
    tick();
    op_valid = 1'b0;
    repeat (5) tick();
    resetn = 1'b0;
    #1;
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rdata", rdata, 0);
    check("rst_mid_dmu_a", dmu_a, 0);
    repeat (2) tick();
    resetn = 1'b1;
    repeat (DIV_LAT) tick();
    check("rst_nocap_hi", hi, 0);
    check("rst_nocap_lo", lo, 0);
    check("rst_nocap_busy", busy, 0);
    check("rst_nocap_start", dmu_start, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_hilo_ctrl
